// File: rtl/scoreboard_hazard_unit.sv
// Per-register pending-write scoreboard at the D->E boundary: decides stall for
// the instr in D and picks the forwarding stage for each of its source operands.
module scoreboard_hazard_unit #(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 3,
  parameter int WB_AGE   = 4,
  localparam int RA_W    = $clog2(NUM_REGS),
  localparam int LAT_W   = $clog2(MAX_LAT + 1),
  localparam int AGE_W   = $clog2(WB_AGE + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic                       issue_wr,
  input  logic [RA_W-1:0]            issue_rd,
  input  logic [LAT_W-1:0]           issue_lat,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC*RA_W-1:0]    src_addr,
  output logic                       stall,
  output logic                       issue_fire,
  output logic [NUM_SRC*AGE_W-1:0]   fwd_sel,
  output logic [NUM_REGS-1:0]        busy_vec
);

  localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);
  localparam logic [AGE_W-1:0] AGE_LAST  = AGE_W'(WB_AGE - 1);

  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [NUM_REGS-1:0][LAT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_REGS-1:0][AGE_W-1:0]  age_q, age_d;

  logic [RA_W-1:0]  src_a;
  logic             hit;
  logic [LAT_W-1:0] lat_c;
  logic             fire_wr;

  // Source lookup against the pre-issue state (reads precede writes).
  always_comb begin
    stall   = 1'b0;
    fwd_sel = '0;
    src_a   = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_a = src_addr[i*RA_W +: RA_W];
      hit   = src_en[i] && (src_a != '0) && busy_q[src_a];
      if (hit && (cnt_q[src_a] != '0)) begin
        stall = 1'b1;
      end
      if (hit && (cnt_q[src_a] == '0)) begin
        fwd_sel[i*AGE_W +: AGE_W] = age_q[src_a] + 1'b1;
      end
    end
  end

  assign issue_fire = issue_valid && !stall && !freeze && !flush;
  assign fire_wr    = issue_fire && issue_wr && (issue_rd != '0);
  assign lat_c      = (issue_lat > MAX_LAT_L) ? MAX_LAT_L : issue_lat;
  assign busy_vec   = busy_q;

  // Advance every in-flight producer; a new issue to the same reg overrides it (youngest wins).
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    age_d  = age_q;
    if (!freeze) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (busy_q[r]) begin
          if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - 1'b1;
          end
          if (age_q[r] == AGE_LAST) begin
            busy_d[r] = 1'b0;
            age_d[r]  = '0;
            cnt_d[r]  = '0;
          end else begin
            age_d[r] = age_q[r] + 1'b1;
          end
        end
      end
      if (fire_wr) begin
        busy_d[issue_rd] = 1'b1;
        cnt_d[issue_rd]  = lat_c;
        age_d[issue_rd]  = '0;
      end
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
    age_d[0]  = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      age_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

  lat_legal_a: assert property (@(posedge clk) disable iff (rst)
    !(issue_valid && issue_wr && (issue_lat > MAX_LAT_L)));

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit: hand-computed stall/forward/busy expectations.
module tb_scoreboard_hazard_unit;

  localparam int RA_W  = 5;
  localparam int LAT_W = 2;
  localparam int AGE_W = 3;

  logic             clk = 1'b0;
  logic             rst, freeze, flush, issue_valid, issue_wr;
  logic [RA_W-1:0]  issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic [1:0]       src_en;
  logic [2*RA_W-1:0] src_addr;
  logic             stall, issue_fire;
  logic [2*AGE_W-1:0] fwd_sel;
  logic [31:0]      busy_vec;

  int vectors    = 0;
  int miscompares = 0;

  scoreboard_hazard_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .src_en(src_en), .src_addr(src_addr),
    .stall(stall), .issue_fire(issue_fire), .fwd_sel(fwd_sel), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    freeze = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0;
    issue_rd = '0; issue_lat = '0; src_en = '0; src_addr = '0;
  endtask

  task automatic issue(input logic wr, input logic [RA_W-1:0] rd, input logic [LAT_W-1:0] lat);
    issue_valid = 1'b1; issue_wr = wr; issue_rd = rd; issue_lat = lat;
  endtask

  task automatic srcs(input logic [1:0] en, input logic [RA_W-1:0] a0, input logic [RA_W-1:0] a1);
    src_en = en; src_addr = {a1, a0};
  endtask

  function automatic logic [31:0] f0();
    return 32'(fwd_sel[0 +: AGE_W]);
  endfunction

  function automatic logic [31:0] f1();
    return 32'(fwd_sel[AGE_W +: AGE_W]);
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fwd", 32'(fwd_sel), 32'd0);
    chk("rst_fire", 32'(issue_fire), 32'd0);

    // T1: ALU x5, then readers walk the forward stage E->M0->M1->WB
    issue(1'b1, 5'd5, 2'd0); #1;
    chk("t1_fire", 32'(issue_fire), 32'd1);
    tick(); idle(); issue(1'b0, 5'd0, 2'd0); srcs(2'b01, 5'd5, 5'd0); #1;
    chk("t1_stall", 32'(stall), 32'd0);
    chk("t1_fwd_e", f0(), 32'd1);
    chk("t1_busy5", 32'(busy_vec[5]), 32'd1);
    tick(); #1;
    chk("t1_fwd_m0", f0(), 32'd2);
    tick(); #1;
    chk("t1_fwd_m1", f0(), 32'd3);
    tick(); #1;
    chk("t1_fwd_wb", f0(), 32'd4);
    tick(); #1;
    chk("t1_retired", 32'(busy_vec[5]), 32'd0);
    chk("t1_fwd_rf", f0(), 32'd0);

    // T2: LOAD x7 read by rs2 -> one stall cycle, then forward from M0
    idle(); issue(1'b1, 5'd7, 2'd1);
    tick(); idle(); issue(1'b0, 5'd0, 2'd0); srcs(2'b10, 5'd0, 5'd7); #1;
    chk("t2_stall", 32'(stall), 32'd1);
    chk("t2_nofire", 32'(issue_fire), 32'd0);
    tick(); #1;
    chk("t2_stall_end", 32'(stall), 32'd0);
    chk("t2_fwd1", f1(), 32'd2);
    chk("t2_fire", 32'(issue_fire), 32'd1);
    tick(); idle(); tick(); tick(); #1;
    chk("t2_clean", busy_vec, 32'd0);

    // T3: MUL x9 with a 3-cycle freeze holding every counter
    issue(1'b1, 5'd9, 2'd2);
    tick(); idle(); issue(1'b0, 5'd0, 2'd0); srcs(2'b01, 5'd9, 5'd0); freeze = 1'b1; #1;
    chk("t3_frz_stall", 32'(stall), 32'd1);
    chk("t3_frz_fire", 32'(issue_fire), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("t3_frz_hold", 32'(stall), 32'd1);
      chk("t3_frz_busy9", 32'(busy_vec[9]), 32'd1);
    end
    freeze = 1'b0; #1;
    chk("t3_stall_a", 32'(stall), 32'd1);
    tick(); #1;
    chk("t3_stall_b", 32'(stall), 32'd1);
    tick(); #1;
    chk("t3_stall_end", 32'(stall), 32'd0);
    chk("t3_fwd_m1", f0(), 32'd3);
    tick(); idle(); tick(); #1;
    chk("t3_clean", busy_vec, 32'd0);

    // T4: WAW on x3, youngest (LOAD) producer governs
    issue(1'b1, 5'd3, 2'd0);
    tick(); issue(1'b1, 5'd3, 2'd1); #1;
    chk("t4_fire_load", 32'(issue_fire), 32'd1);
    tick(); idle(); issue(1'b0, 5'd0, 2'd0); srcs(2'b01, 5'd3, 5'd0); #1;
    chk("t4_stall", 32'(stall), 32'd1);
    tick(); #1;
    chk("t4_stall_end", 32'(stall), 32'd0);
    chk("t4_fwd_m0", f0(), 32'd2);
    tick(); idle(); tick(); #1;
    chk("t4_busy3_age3", 32'(busy_vec[3]), 32'd1);
    tick(); #1;
    chk("t4_busy3_clr", 32'(busy_vec[3]), 32'd0);

    // T5: flushed write to x4 never issues; x6 keeps aging
    issue(1'b1, 5'd6, 2'd0);
    tick(); idle(); issue(1'b1, 5'd4, 2'd0); flush = 1'b1; srcs(2'b01, 5'd6, 5'd0); #1;
    chk("t5_nofire", 32'(issue_fire), 32'd0);
    chk("t5_fwd_e", f0(), 32'd1);
    tick(); flush = 1'b0; issue_valid = 1'b0; #1;
    chk("t5_busy4", 32'(busy_vec[4]), 32'd0);
    chk("t5_fwd_aged", f0(), 32'd2);
    tick(); idle(); tick(); tick(); #1;
    chk("t5_clean", busy_vec, 32'd0);

    // T6: x0 never tracked, src_en=0 ignored, reset mid-MUL
    issue(1'b1, 5'd0, 2'd2); #1;
    chk("t6_fire_x0", 32'(issue_fire), 32'd1);
    tick(); idle(); srcs(2'b11, 5'd0, 5'd0); #1;
    chk("t6_busy_x0", busy_vec, 32'd0);
    chk("t6_stall_x0", 32'(stall), 32'd0);
    chk("t6_fwd_x0", 32'(fwd_sel), 32'd0);
    idle(); issue(1'b1, 5'd10, 2'd2);
    tick(); idle(); srcs(2'b00, 5'd10, 5'd10); #1;
    chk("t6_en0_stall", 32'(stall), 32'd0);
    chk("t6_en0_fwd", 32'(fwd_sel), 32'd0);
    srcs(2'b01, 5'd10, 5'd0); #1;
    chk("t6_en1_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("t6_rst_busy", busy_vec, 32'd0);
    chk("t6_rst_stall", 32'(stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
